// File: rtl/cpu_defs.sv
// Shared CPU definitions: divider sequencer state encoding and the
// DIV/DIVU funct codes used by the decoder that drives divE/signed_divE.
package cpu_defs;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } divState_t;

   localparam logic [5:0] FUNCT_DIV  = 6'b011010;
   localparam logic [5:0] FUNCT_DIVU = 6'b011011;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration, purely combinational.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] remNext,
   output logic [WIDTH-1:0] quoNext
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] trial;
   logic           borrow;

   // One extra bit keeps the shifted remainder exact; the MSB of the
   // difference is the borrow.
   assign shifted = {rem, quo[WIDTH-1]};
   assign trial   = shifted - {1'b0, divisor};
   assign borrow  = trial[WIDTH];

   assign remNext = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
   assign quoNext = {quo[WIDTH-2:0], ~borrow};

endmodule

// File: rtl/div_ctrl.sv
// Execute-stage sequencer for the iterative DIV/DIVU unit: stalls the pipe
// while iterating, applies sign fixup, abandons work on flush.
module div_ctrl
   import cpu_defs::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             divE,
   input  logic             signed_divE,
   input  logic [WIDTH-1:0] srcaE,
   input  logic [WIDTH-1:0] srcbE,
   input  logic             flushE,
   input  logic             stall_extE,
   output logic             stall_divE,
   output logic             div_validE,
   output logic [WIDTH-1:0] div_hiE,
   output logic [WIDTH-1:0] div_loE
);

   divState_t        state, stateNext;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] rem, quo, divisor;
   logic [WIDTH-1:0] remNext, quoNext;
   logic [WIDTH-1:0] hiReg, loReg;
   logic             signQ, signR;
   logic             aNeg, bNeg;
   logic             start, lastStep;

   assign aNeg     = signed_divE & srcaE[WIDTH-1];
   assign bNeg     = signed_divE & srcbE[WIDTH-1];
   assign start    = (state == IDLE) & divE & ~flushE;
   assign lastStep = (state == BUSY) & (cnt == CNT_W'(WIDTH-1));

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem     (rem),
      .quo     (quo),
      .divisor (divisor),
      .remNext (remNext),
      .quoNext (quoNext)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (start) stateNext = BUSY;
         BUSY:    if (flushE) stateNext = IDLE;
                  else if (lastStep) stateNext = DONE;
         // Holding DONE under an external stall keeps the lingering divE
         // from being seen as a fresh request.
         DONE:    if (flushE || !stall_extE) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_comb begin
      stall_divE = 1'b0;
      div_validE = 1'b0;
      case (state)
         IDLE:    stall_divE = start;
         BUSY:    stall_divE = ~flushE;
         DONE:    div_validE = ~flushE;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         rem     <= '0;
         quo     <= '0;
         divisor <= '0;
         signQ   <= 1'b0;
         signR   <= 1'b0;
         hiReg   <= '0;
         loReg   <= '0;
      end else if (start) begin
         cnt     <= '0;
         rem     <= '0;
         quo     <= aNeg ? -srcaE : srcaE;
         divisor <= bNeg ? -srcbE : srcbE;
         signQ   <= aNeg ^ bNeg;
         signR   <= aNeg;
      end else if (state == BUSY && !flushE) begin
         cnt <= cnt + 1'b1;
         rem <= remNext;
         quo <= quoNext;
         if (lastStep) begin
            loReg <= signQ ? -quoNext : quoNext;
            hiReg <= signR ? -remNext : remNext;
         end
      end
   end

   assign div_hiE = hiReg;
   assign div_loE = loReg;

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Sequencer for a multi-cycle iterative (radix-2 restoring) divider serving DIV/DIVU in the execute stage.
- Accepts a divide request from the E-stage control bits (divE, signed_divE) and stalls the pipeline while the divide runs.
- Delivers quotient/remainder for the hi/lo write path and abandons the operation on an exception flush.
- Sits beside the ALU; its stall output is ORed into the hazard unit's stallE and stallD.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- divE  in  1  E-stage instruction is DIV/DIVU.
- signed_divE  in  1  1 = DIV (signed), 0 = DIVU.
- srcaE  in  WIDTH  dividend (rs).
- srcbE  in  WIDTH  divisor (rt).
- flushE  in  1  exception/flush of the E stage.
- stall_extE  in  1  E stage held by a hazard other than this block.
- stall_divE  out  1  request pipeline stall; combinational.
- div_validE  out  1  result valid for the E-stage instruction.
- div_hiE  out  WIDTH  remainder.
- div_loE  out  WIDTH  quotient.

Behaviour:
- Reset: state=IDLE, counter=0, all datapath registers=0. div_validE=0, div_hiE=0, div_loE=0. stall_divE=0 (no request is in flight after reset).
- States: IDLE, BUSY, DONE.
- IDLE:
  - start = divE & ~flushE.
  - On start, stall_divE=1 in the same cycle.
  - Latch |dividend| and |divisor|: absolute values when signed_divE=1, raw values otherwise.
  - Latch sign_q = a[31]^b[31] and sign_r = a[31] (both forced to 0 for DIVU).
  - Clear the partial remainder; counter=0; go to BUSY.
- BUSY:
  - stall_divE=1.
  - Each cycle performs one restoring step: shift {rem,quo} left 1, trial-subtract the divisor, set quo[0] if no borrow.
  - counter increments each step; after WIDTH steps (counter==WIDTH-1 at the edge) go to DONE.
  - On that final edge, apply sign fixup into the output registers: lo = sign_q ? -quo : quo; hi = sign_r ? -rem : rem.
- Latency: start cycle T; BUSY T+1..T+WIDTH; DONE at T+WIDTH+1. stall_divE is high T..T+WIDTH and low in DONE.
- DONE:
  - div_validE=1; stall_divE=0.
  - If stall_extE=1: remain in DONE, holding outputs and valid, so the still-present divE does not restart the divide.
  - If stall_extE=0: go to IDLE next cycle; div_hiE/div_loE keep their value until the next start.
- flushE:
  - In any state, force state to IDLE at the next edge.
  - div_validE=0 and stall_divE=0 in that cycle.
  - No result is produced.
  - flushE together with divE in IDLE: no start.
- Divide by zero: the iteration runs unchanged; no special case and no trap. Required result is lo=all-ones for DIVU; hi=dividend.
- Signed overflow 0x80000000 / -1: lo=0x80000000, hi=0 (natural wrap of negation).
- Arithmetic:
  - The trial subtraction is WIDTH+1 bits wide; borrow = MSB.
  - Negation is two's complement modulo 2**WIDTH.
- rst during BUSY: all state returns to reset values at that edge.

Decomposition:
- Shared package (cpu_defs):
  - div state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2).
  - DIV/DIVU funct constants (6'b011010, 6'b011011) for the decoder that produces divE/signed_divE.
- Sub-module div_step: purely combinational single restoring iteration.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, next quo.
  - div_ctrl holds the FSM, counter, sign logic and registers.

Test Plan:
- DIVU 100/7, no external stall:
  - stall_divE high for 33 cycles.
  - DONE at T+33: div_validE=1, lo=14, hi=2, stall_divE=0.
  - IDLE at T+34.
- DIV -7/2 (0xFFFFFFF9/0x00000002): lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 7/-2: lo=0xFFFFFFFD, hi=1.
- DIV 0x80000000/0xFFFFFFFF: lo=0x80000000, hi=0. DIVU 5/0: lo=0xFFFFFFFF, hi=5; no hang.
- flushE asserted at T+10 during BUSY:
  - T+11 state IDLE, stall_divE=0, div_validE never asserted.
  - A new divE at T+12 starts a fresh 33-cycle divide with a correct result.
- stall_extE=1 for 3 cycles entering DONE with divE held high:
  - div_validE stays 1 for 3 cycles with stable hi/lo and no restart.
  - IDLE the cycle after stall_extE drops.
- rst asserted at T+5 during BUSY: next cycle all outputs 0, state IDLE. Back-to-back DIVU requests each take 33 stall cycles with independent results.
